// File: rtl/dma_ctrl.sv
// Block-copy DMA responder: moves word blocks between DRAM (req/ack) and on-chip SRAM
// while holding the pipeline stalled; one word in flight at a time.
module dma_ctrl #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LEN_W  = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        dmaCmd,
  input  logic [ADDR_W-1:0] dmaSrcAddress,
  input  logic [ADDR_W-1:0] dmaDstAddress,
  input  logic [LEN_W-1:0]  dmaWidth,
  output logic              stall,
  output logic [ADDR_W-1:0] sramAddress,
  output logic              sramWriteEnable,
  output logic [31:0]       sramWriteData,
  input  logic [31:0]       sramReadData,
  output logic              dramReq,
  output logic              dramWe,
  output logic [ADDR_W-1:0] dramAddress,
  output logic [31:0]       dramWriteData,
  input  logic [31:0]       dramReadData,
  input  logic              dramAck
);

  typedef enum logic [2:0] {
    StIdle,
    StD2sReq,
    StD2sWr,
    StS2dRd,
    StS2dCap,
    StS2dReq,
    StDone
  } state_e;

  localparam logic [1:0] CmdD2s = 2'b01;
  localparam logic [1:0] CmdS2d = 2'b10;

  state_e            r_state;
  state_e            w_state_next;
  logic [ADDR_W-1:0] r_src;
  logic [ADDR_W-1:0] r_dst;
  logic [LEN_W-1:0]  r_count;
  logic [31:0]       r_data;
  logic              r_rearm_block;

  logic              w_valid_cmd;
  logic              w_accept;
  logic              w_last;
  logic              w_step;

  assign w_valid_cmd = (dmaCmd == CmdD2s) || (dmaCmd == CmdS2d);
  // A command still held after completion must drop before it can be taken again.
  assign w_accept    = (r_state == StIdle) && w_valid_cmd && (dmaWidth != '0) &&
                       !r_rearm_block && !reset;
  assign w_last      = (r_count == LEN_W'(1));
  assign w_step      = (r_state == StD2sWr) || ((r_state == StS2dReq) && dramAck);

  always_comb begin
    w_state_next    = r_state;
    stall           = 1'b0;
    sramAddress     = '0;
    sramWriteEnable = 1'b0;
    sramWriteData   = '0;
    dramReq         = 1'b0;
    dramWe          = 1'b0;
    dramAddress     = '0;
    dramWriteData   = '0;

    case (r_state)
      StIdle: begin
        if (w_accept) begin
          stall        = 1'b1;
          w_state_next = (dmaCmd == CmdD2s) ? StD2sReq : StS2dRd;
        end
      end
      StD2sReq: begin
        stall       = 1'b1;
        dramReq     = 1'b1;
        dramAddress = r_src;
        if (dramAck) begin
          w_state_next = StD2sWr;
        end
      end
      StD2sWr: begin
        stall           = 1'b1;
        sramWriteEnable = 1'b1;
        sramAddress     = r_dst;
        sramWriteData   = r_data;
        w_state_next    = w_last ? StDone : StD2sReq;
      end
      StS2dRd: begin
        stall        = 1'b1;
        sramAddress  = r_src;
        w_state_next = StS2dCap;
      end
      StS2dCap: begin
        stall        = 1'b1;
        w_state_next = StS2dReq;
      end
      StS2dReq: begin
        stall         = 1'b1;
        dramReq       = 1'b1;
        dramWe        = 1'b1;
        dramAddress   = r_dst;
        dramWriteData = r_data;
        if (dramAck) begin
          w_state_next = w_last ? StDone : StS2dRd;
        end
      end
      StDone: begin
        w_state_next = StIdle;
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase

    // Abort immediately: no strobe may escape in the cycle reset is sampled.
    if (reset) begin
      stall           = 1'b0;
      sramWriteEnable = 1'b0;
      dramReq         = 1'b0;
      dramWe          = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= StIdle;
      r_src         <= '0;
      r_dst         <= '0;
      r_count       <= '0;
      r_data        <= '0;
      r_rearm_block <= 1'b0;
    end else begin
      r_state <= w_state_next;

      if (r_state == StDone) begin
        r_rearm_block <= 1'b1;
      end else if (!w_valid_cmd) begin
        r_rearm_block <= 1'b0;
      end

      if (w_accept) begin
        r_src   <= dmaSrcAddress;
        r_dst   <= dmaDstAddress;
        r_count <= dmaWidth;
      end

      if ((r_state == StD2sReq) && dramAck) begin
        r_data <= dramReadData;
      end else if (r_state == StS2dCap) begin
        r_data <= sramReadData;
      end

      if (w_step) begin
        r_src   <= r_src + ADDR_W'(4);
        r_dst   <= r_dst + ADDR_W'(4);
        r_count <= r_count - LEN_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_dma_ctrl.sv
// Bench for dma_ctrl: SRAM/DRAM models, directed corner cases and random transfers
// scored against expectations computed from the block-copy rules.
module tb_dma_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  dmaCmd;
  logic [31:0] dmaSrcAddress;
  logic [31:0] dmaDstAddress;
  logic [9:0]  dmaWidth;
  logic        stall;
  logic [31:0] sramAddress;
  logic        sramWriteEnable;
  logic [31:0] sramWriteData;
  logic [31:0] sramReadData;
  logic        dramReq;
  logic        dramWe;
  logic [31:0] dramAddress;
  logic [31:0] dramWriteData;
  logic [31:0] dramReadData;
  logic        dramAck;

  int n_compared   = 0;
  int n_mismatched = 0;

  bit   [31:0] sram_mem [0:16383];
  logic        pre_we   = 1'b0;
  logic [13:0] pre_idx  = '0;
  logic [31:0] pre_data = '0;
  int          dram_lat  = 0;
  int          dram_wait = 0;
  int          stall_cycles = 0;

  logic [31:0] sram_wr_addr [$];
  logic [31:0] sram_wr_data [$];
  logic [31:0] dram_addr_q  [$];
  logic [31:0] dram_data_q  [$];
  logic        dram_we_q    [$];

  always #5 clk = ~clk;

  dma_ctrl #(.ADDR_W(32), .LEN_W(10)) u_dut (
    .clk             (clk),
    .reset           (reset),
    .dmaCmd          (dmaCmd),
    .dmaSrcAddress   (dmaSrcAddress),
    .dmaDstAddress   (dmaDstAddress),
    .dmaWidth        (dmaWidth),
    .stall           (stall),
    .sramAddress     (sramAddress),
    .sramWriteEnable (sramWriteEnable),
    .sramWriteData   (sramWriteData),
    .sramReadData    (sramReadData),
    .dramReq         (dramReq),
    .dramWe          (dramWe),
    .dramAddress     (dramAddress),
    .dramWriteData   (dramWriteData),
    .dramReadData    (dramReadData),
    .dramAck         (dramAck)
  );

  // DRAM contents are a fixed function of address; writes are only logged.
  function automatic logic [31:0] dram_init(input logic [31:0] a);
    return {a[15:0] ^ 16'hA5C3, a[31:16]} + 32'h1357_9BDF;
  endfunction

  assign dramAck      = dramReq && (dram_wait == dram_lat);
  assign dramReadData = dramReq ? dram_init(dramAddress) : 32'h0;

  always @(posedge clk) begin
    if (pre_we) begin
      sram_mem[pre_idx] <= pre_data;
    end else if (sramWriteEnable) begin
      sram_mem[sramAddress[15:2]] <= sramWriteData;
      sram_wr_addr.push_back(sramAddress);
      sram_wr_data.push_back(sramWriteData);
    end
    sramReadData <= sram_mem[sramAddress[15:2]];
    if (dramReq && dramAck) begin
      dram_addr_q.push_back(dramAddress);
      dram_data_q.push_back(dramWriteData);
      dram_we_q.push_back(dramWe);
      dram_wait <= 0;
    end else if (dramReq) begin
      dram_wait <= dram_wait + 1;
    end else begin
      dram_wait <= 0;
    end
    if (stall) stall_cycles <= stall_cycles + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic sram_poke(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    pre_we   = 1'b1;
    pre_idx  = addr[15:2];
    pre_data = data;
    @(negedge clk);
    pre_we   = 1'b0;
  endtask

  // Runs one transfer as the core would: command held until the DONE cycle
  // (plus hold_after idle cycles), then scores it against the copy rules.
  task automatic run_xfer(input logic [1:0] cmd, input logic [31:0] src, input logic [31:0] dst,
                          input int n, input int lat, input int hold_after);
    logic [31:0] exp_w [0:255];
    logic [31:0] a, b;
    int s0, d0, st0, cyc, per_word;
    for (int i = 0; i < n; i++) begin
      a = src + 32'(4 * i);
      exp_w[i] = (cmd == 2'b01) ? dram_init(a) : sram_mem[a[15:2]];
    end
    per_word = (cmd == 2'b01) ? 2 : 3;
    s0  = sram_wr_addr.size();
    d0  = dram_addr_q.size();
    st0 = stall_cycles;
    @(negedge clk);
    dram_lat      = lat;
    dmaCmd        = cmd;
    dmaSrcAddress = src;
    dmaDstAddress = dst;
    dmaWidth      = 10'(n);
    #1;
    check_eq("accept_stall", {31'b0, stall}, 32'd1);
    cyc = 0;
    while (stall !== 1'b0 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 2000) check_eq("xfer_timeout", {31'b0, stall}, 32'd0);
    check_eq("done_stall", {31'b0, stall}, 32'd0);
    check_eq("done_no_req", {31'b0, dramReq}, 32'd0);
    check_eq("done_no_swe", {31'b0, sramWriteEnable}, 32'd0);
    for (int k = 0; k < hold_after; k++) begin
      @(negedge clk);
      #1;
      check_eq("held_cmd_stall", {31'b0, stall}, 32'd0);
    end
    @(negedge clk);
    dmaCmd = 2'b00;
    repeat (3) @(negedge clk);
    check_eq("stall_cycles", 32'(stall_cycles - st0), 32'(1 + n * (lat + per_word)));
    check_eq("dram_count", 32'(dram_addr_q.size() - d0), 32'(n));
    check_eq("sram_wr_count", 32'(sram_wr_addr.size() - s0), (cmd == 2'b01) ? 32'(n) : 32'd0);
    for (int i = 0; i < n; i++) begin
      a = src + 32'(4 * i);
      b = dst + 32'(4 * i);
      if (d0 + i < dram_addr_q.size()) begin
        check_eq("dram_addr", dram_addr_q[d0 + i], (cmd == 2'b01) ? a : b);
        check_eq("dram_we", {31'b0, dram_we_q[d0 + i]}, (cmd == 2'b01) ? 32'd0 : 32'd1);
        if (cmd == 2'b10) check_eq("dram_wdata", dram_data_q[d0 + i], exp_w[i]);
      end
      if (cmd == 2'b01 && s0 + i < sram_wr_addr.size()) begin
        check_eq("sram_waddr", sram_wr_addr[s0 + i], b);
        check_eq("sram_wdata", sram_wr_data[s0 + i], exp_w[i]);
        check_eq("sram_mem", sram_mem[b[15:2]], exp_w[i]);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, d0, cyc, n, lat;
    logic [1:0]  cmd;
    logic [31:0] src, dst;

    reset         = 1'b1;
    dmaCmd        = 2'b00;
    dmaSrcAddress = '0;
    dmaDstAddress = '0;
    dmaWidth      = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check_eq("rst_stall", {31'b0, stall}, 32'd0);
    check_eq("rst_req", {31'b0, dramReq}, 32'd0);
    check_eq("rst_we", {31'b0, dramWe}, 32'd0);
    check_eq("rst_swe", {31'b0, sramWriteEnable}, 32'd0);
    check_eq("rst_saddr", sramAddress, 32'd0);
    check_eq("rst_daddr", dramAddress, 32'd0);

    // d2s, 4 words, L=2: 17 stall cycles, SRAM words 16..19
    run_xfer(2'b01, 32'h100, 32'h40, 4, 2, 0);

    // s2d, 3 words, L=0 from SRAM[4..6]
    sram_poke(32'h10, 32'd7);
    sram_poke(32'h14, 32'd8);
    sram_poke(32'h18, 32'd9);
    run_xfer(2'b10, 32'h10, 32'h200, 3, 0, 0);

    // reserved command and zero width are ignored
    s0 = sram_wr_addr.size();
    d0 = dram_addr_q.size();
    @(negedge clk);
    dmaCmd   = 2'b11;
    dmaWidth = 10'd5;
    for (int k = 0; k < 3; k++) begin
      #1;
      check_eq("cmd11_stall", {31'b0, stall}, 32'd0);
      check_eq("cmd11_req", {31'b0, dramReq}, 32'd0);
      @(negedge clk);
    end
    dmaCmd   = 2'b01;
    dmaWidth = 10'd0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check_eq("w0_stall", {31'b0, stall}, 32'd0);
      check_eq("w0_swe", {31'b0, sramWriteEnable}, 32'd0);
      @(negedge clk);
    end
    dmaCmd = 2'b00;
    @(negedge clk);
    check_eq("ignored_dram", 32'(dram_addr_q.size() - d0), 32'd0);
    check_eq("ignored_sram", 32'(sram_wr_addr.size() - s0), 32'd0);

    // single word, command held through DONE and two cycles after
    run_xfer(2'b01, 32'h300, 32'h80, 1, 1, 2);

    // reset during the second word of a 4-word d2s
    s0 = sram_wr_addr.size();
    d0 = dram_addr_q.size();
    @(negedge clk);
    dram_lat      = 2;
    dmaCmd        = 2'b01;
    dmaSrcAddress = 32'h500;
    dmaDstAddress = 32'h40;
    dmaWidth      = 10'd4;
    cyc = 0;
    while (sram_wr_addr.size() == s0 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 100) check_eq("rst_mid_wait", 32'(sram_wr_addr.size() - s0), 32'd1);
    reset  = 1'b1;
    dmaCmd = 2'b00;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_eq("rst_mid_stall", {31'b0, stall}, 32'd0);
    check_eq("rst_mid_req", {31'b0, dramReq}, 32'd0);
    repeat (4) @(negedge clk);
    check_eq("rst_mid_sram_n", 32'(sram_wr_addr.size() - s0), 32'd1);
    if (sram_wr_addr.size() > s0) check_eq("rst_mid_waddr", sram_wr_addr[s0], 32'h40);
    check_eq("rst_mid_dram_n", 32'(dram_addr_q.size() - d0), 32'd1);
    run_xfer(2'b01, 32'h600, 32'h40, 4, 1, 0);

    // destination wraps past the top of the address space
    run_xfer(2'b01, 32'h1000, 32'hFFFF_FFFC, 2, 1, 0);
    if (sram_wr_addr.size() > 0)
      check_eq("wrap_addr", sram_wr_addr[sram_wr_addr.size() - 1], 32'h0000_0000);

    // randomized transfers
    for (int t = 0; t < 10; t++) begin
      cmd = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
      n   = $urandom_range(1, 8);
      lat = $urandom_range(0, 3);
      src = $urandom & 32'hFFFF_FFFC;
      dst = $urandom & 32'hFFFF_FFFC;
      if (cmd == 2'b10) begin
        for (int i = 0; i < n; i++) sram_poke(src + 32'(4 * i), $urandom);
      end
      run_xfer(cmd, src, dst, n, lat, $urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/dma_ctrl.md
Name: dma_ctrl

Overview:
- DMA responder for the `dmaCmd`/`dmaSrcAddress`/`dmaDstAddress`/`dmaWidth` initiator interface of `mips_pipeline`.
- Copies word blocks between off-chip DRAM (req/ack port) and on-chip data SRAM, in either direction.
- Holds the core frozen through `stall` for the whole transfer.
- Sits beside `mips_pipeline` and `sram` in the top level. The top level muxes the SRAM port to this block whenever `stall`=1.

Parameters:
- ADDR_W, 32, byte-address width of SRAM and DRAM addresses
- LEN_W, 10, width of dmaWidth (word count)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset, sampled on rising edge of clk
- dmaCmd  in  2  00 none, 01 DRAM->SRAM (d2s), 10 SRAM->DRAM (s2d), 11 reserved
- dmaSrcAddress  in  ADDR_W  source byte address, word aligned
- dmaDstAddress  in  ADDR_W  destination byte address, word aligned
- dmaWidth  in  LEN_W  number of 32-bit words to move
- stall  out  1  freeze request to pipeline
- sramAddress  out  ADDR_W  SRAM byte address (top level uses [15:2])
- sramWriteEnable  out  1  SRAM write strobe
- sramWriteData  out  32  SRAM write data
- sramReadData  in  32  SRAM read data, valid the cycle after address (synchronous read)
- dramReq  out  1  DRAM request, held until dramAck
- dramWe  out  1  1 = write, 0 = read; valid while dramReq
- dramAddress  out  ADDR_W  DRAM byte address
- dramWriteData  out  32  DRAM write data
- dramReadData  in  32  valid in the dramAck cycle of a read
- dramAck  in  1  one-cycle completion pulse; may come in first req cycle

Behaviour:
- Reset: state IDLE; stall, sramWriteEnable, dramReq, dramWe = 0; address/data regs = 0. Reset mid-transfer aborts at once: already-written words remain, the rest are untouched, and no further req/write is issued.
- States: IDLE, D2S_REQ, D2S_WR, S2D_RD, S2D_CAP, S2D_REQ, DONE.
- Accept condition: state IDLE and dmaCmd is 01 or 10 and dmaWidth != 0.
- Stall is combinational: 1 in the accept cycle and in every non-IDLE, non-DONE state; 0 otherwise.
- On accept: latch src, dst, count = dmaWidth, dir. Go to D2S_REQ (01) or S2D_RD (10).
- dmaCmd 00, 11, or dmaWidth = 0 in IDLE: ignored; stall stays 0.
- dmaCmd and addresses are ignored outside IDLE. The core keeps them held while stalled; only the latched copies are used.
- D2S_REQ:
  - dramReq=1, dramWe=0, dramAddress=src.
  - On dramAck: capture dramReadData, go to D2S_WR.
- D2S_WR:
  - sramWriteEnable=1, sramAddress=dst, sramWriteData=captured word.
  - Then src+=4, dst+=4, count-=1.
  - Go to DONE if count was 1, else D2S_REQ.
- S2D_RD: sramAddress=src, sramWriteEnable=0; go to S2D_CAP.
- S2D_CAP: capture sramReadData; go to S2D_REQ.
- S2D_REQ:
  - dramReq=1, dramWe=1, dramAddress=dst, dramWriteData=captured word.
  - On dramAck: src+=4, dst+=4, count-=1.
  - Go to DONE if count was 1, else S2D_RD.
- DONE:
  - stall=0 for one cycle, so the pipeline advances the DMA instruction.
  - dmaCmd still asserted this cycle is not re-accepted.
  - Go to IDLE.
- Latency (L = wait cycles before dramAck, L≥0):
  - d2s stall-high cycles = 1 + N·(L+2).
  - s2d stall-high cycles = 1 + N·(L+3).
- Address arithmetic wraps modulo 2^ADDR_W. No alignment check; bits [1:0] pass through unchanged.
- Max transfer 2^LEN_W−1 words. count is LEN_W bits and never underflows.
- Outputs not named for a state are 0. sramWriteEnable is never asserted in IDLE/DONE.

Test Plan:
- d2s, src=0x100, dst=0x40, width=4, DRAM model L=2, words A0..A3:
  - stall high exactly 17 cycles.
  - SRAM words 16..19 = A0..A3.
  - dramAddress sequence 0x100, 0x104, 0x108, 0x10C.
- s2d, src=0x10, dst=0x200, width=3, L=0, SRAM[4..6]=7,8,9:
  - stall high 10 cycles.
  - DRAM writes (0x200,7), (0x204,8), (0x208,9).
  - dramWe=1 on each.
- dmaCmd=11, width=5 held 3 cycles; separately dmaCmd=01, width=0:
  - stall stays 0, no dramReq, no SRAM write.
- dmaCmd=01, width=1 held through DONE and 2 cycles after:
  - exactly one DRAM read and one SRAM write.
  - stall low in DONE cycle.
- reset=1 for one cycle during the 2nd word of an 4-word d2s:
  - next cycle stall=0, dramReq=0.
  - only SRAM word 16 written.
  - a fresh command then completes normally.
- d2s, dst=0xFFFFFFFC, width=2:
  - second SRAM write goes to address 0x00000000.
